acp_mm2s_mover: RTL
===================

// Module: acp_mm2s_mover
// PURPOSE
//  Read-side data mover. Sits downstream of the host-to-accelerator axi4_stream_master command/status interface.
//  Turns each 72-bit command into 64-bit INCR read bursts on the ACP (M_AXI_AR*/R*).
//  Forwards the returned data as an AXI4-Stream to the custom hardware, then returns one 8-bit status per command.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32       ACP address width
//  C_M_AXI_DATA_WIDTH  64       ACP/stream data width; only 64 is supported
//  C_MAX_BURST         16       max beats per AR burst (ACP limit), power of 2, 1..16
//  C_PROT              3'b010   driven on M_AXI_ARPROT
//  C_CACHE             4'b1111  driven on M_AXI_ARCACHE (coherent ACP access)
// PORTS
//  clk                 in   1   clock; all logic on rising edge
//  rstn                in   1   synchronous reset, active low
//  S_AXIS_CMD_TVALID   in   1   command valid
//  S_AXIS_CMD_TREADY   out  1   command ready
//  S_AXIS_CMD_TDATA    in   72  [22:0]BTT [30]EOF [63:32]SADDR [67:64]TAG; other bits ignored
//  M_AXIS_STS_TVALID   out  1   status valid
//  M_AXIS_STS_TREADY   in   1   status ready
//  M_AXIS_STS_TDATA    out  8   [3:0]TAG [4]INTERR [5]DECERR [6]SLVERR [7]OKAY
//  M_AXI_ARADDR        out  32  burst address
//  M_AXI_ARVALID/ARREADY out/in 1 AR handshake
//  M_AXI_ARLEN         out  8   beats-1
//  M_AXI_ARSIZE/ARBURST out 3/2 constant 3'b011 / 2'b01
//  M_AXI_ARPROT/ARCACHE out 3/4 = C_PROT / C_CACHE
//  M_AXI_RDATA/RRESP/RLAST in 64/2/1 read data
//  M_AXI_RVALID/RREADY in/out 1 R handshake
//  M_AXIS_TDATA/TVALID/TLAST out 64/1/1 data stream to hardware
//  M_AXIS_TREADY       in   1   stream ready
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge): state=IDLE; every VALID output=0; S_AXIS_CMD_TREADY=0; M_AXI_RREADY=0.
//  Reset also clears all counters and error flags; all data outputs read 0.
//  FSM states: IDLE -> ADDR -> DATA -> (ADDR | STS) -> IDLE.
//  IDLE: S_AXIS_CMD_TREADY=1. On handshake, latch addr, beats=BTT>>3, tag, eof and clear error flags.
//   Command is illegal if BTT==0, BTT[2:0]!=0 or SADDR[2:0]!=0: go to STS with INTERR=1; no bus traffic.
//   Otherwise go to ADDR.
//  ADDR: burst = min(remaining beats, C_MAX_BURST, beats to next 4 KB boundary).
//   ARADDR/ARLEN are registered; ARVALID stays high until ARREADY; one burst outstanding at a time.
//  DATA: M_AXIS_TVALID = RVALID, M_AXI_RREADY = M_AXIS_TREADY, TDATA = RDATA.
//   The data path is combinational pass-through with 0-cycle latency; beats move only when both sides are ready.
//   TLAST=1 on the final beat of the command when EOF=1, else 0.
//   RRESP=10 sets SLVERR and RRESP=11 sets DECERR (both sticky); data is still forwarded.
//   Beat counting decides the burst end, not RLAST. RLAST early, or missing on the counted last beat, sets INTERR.
//   After the last burst beat: go to ADDR if beats remain, else STS.
//  STS: M_AXIS_STS_TVALID=1, holding TDATA stable until TREADY; OKAY=~(INTERR|DECERR|SLVERR). Then go to IDLE.
//   A new command is accepted no earlier than the cycle after the status handshake.
//  Arithmetic: address advances by 8*burst; low 12 bits wrap across the 4 KB page; beat counter 20 bits.
//  Reset mid-operation abandons the command with no status emitted; the ACP side must be reset together.
//  Command TREADY=0 in every state except IDLE (no queuing).
// CONFIGURATION
//  ACP_MOVER_STATS_EN defined: adds outputs stat_cmds[31:0] and stat_beats[31:0].
//   stat_cmds increments on each status handshake; stat_beats on each stream beat.
//   Both are free-running, wrap at 2^32, and are cleared by rstn.
//  Not defined: these ports and their counters do not exist; all other behaviour is identical.
// TESTING
//  BTT=64, SADDR=0x1000, TAG=3, EOF=1, ARREADY/RVALID/TREADY always 1
//   -> one AR, ARLEN=7; 8 beats with TLAST on beat 8; then status 0x83.
//  BTT=256, SADDR=0x2000 -> two bursts, ARADDR 0x2000 then 0x2080, ARLEN=15 each; 32 beats.
//  BTT=64, SADDR=0x0FE0 (4 KB crossing) -> bursts ARLEN=3 @0x0FE0 then ARLEN=3 @0x1000.
//  BTT=12 or SADDR=0x1004, TAG=5 -> no ARVALID; status 0x15.
//  BTT=32, RRESP=10 on beat 2, random TREADY stalls, TAG=1 -> 4 beats, data intact, no beat lost; status 0x41.
//  rstn=0 during DATA beat 3, then BTT=8 command -> only the new burst appears; status OKAY with the new tag.

Source files
------------

// File: rtl/acp_mm2s_mover.sv
// acp_mm2s_mover: converts 72-bit read commands into 64-bit INCR bursts on the ACP,
// streams the returned data out and returns one status byte per command.
// Optional build macro ACP_MOVER_STATS_EN adds the stat_cmds / stat_beats counters.
module acp_mm2s_mover #(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter int         C_M_AXI_DATA_WIDTH = 64,
  parameter int         C_MAX_BURST        = 16,
  parameter logic [2:0] C_PROT             = 3'b010,
  parameter logic [3:0] C_CACHE            = 4'b1111
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          S_AXIS_CMD_TVALID,
  output logic                          S_AXIS_CMD_TREADY,
  input  logic [71:0]                   S_AXIS_CMD_TDATA,
  output logic                          M_AXIS_STS_TVALID,
  input  logic                          M_AXIS_STS_TREADY,
  output logic [7:0]                    M_AXIS_STS_TDATA,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARCACHE,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY
`ifdef ACP_MOVER_STATS_EN
  ,
  output logic [31:0]                   stat_cmds,
  output logic [31:0]                   stat_beats
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_STS} state_t;

  localparam logic [19:0] MAX_BEATS = 20'(C_MAX_BURST);

  state_t                          state, state_nxt;
  logic                            run_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_r;
  logic [7:0]                      arlen_r;
  logic                            arvalid_r;
  logic [19:0]                     beats_rem;
  logic [4:0]                      burst_left;
  logic [3:0]                      tag_r;
  logic                            eof_r;
  logic                            interr_r, decerr_r, slverr_r;
  logic                            cmd_hs, cmd_bad, beat, burst_end, issue;
  logic [4:0]                      burst_w;
  logic                            unused_cmd_bits;

  // Beats for the next burst: bounded by what is left, the ACP burst limit
  // and the distance to the next 4 KB page boundary.
  function automatic logic [4:0] calc_burst(input logic [19:0] rem, input logic [11:0] lo);
    logic [9:0]  page_beats;
    logic [19:0] b;
    page_beats = 10'((13'h1000 - {1'b0, lo}) >> 3);
    b = rem;
    if (b > MAX_BEATS) b = MAX_BEATS;
    if (b > {10'd0, page_beats}) b = {10'd0, page_beats};
    return 5'(b);
  endfunction

  assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31], S_AXIS_CMD_TDATA[29:23]};

  assign cmd_bad = (S_AXIS_CMD_TDATA[22:0] == 23'd0) || (S_AXIS_CMD_TDATA[2:0] != 3'd0) ||
                   (S_AXIS_CMD_TDATA[34:32] != 3'd0);
  assign burst_w = calc_burst(beats_rem, addr_r[11:0]);
  assign issue   = (state == S_ADDR) && !arvalid_r;

  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_ARLEN   = arlen_r;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARPROT  = C_PROT;
  assign M_AXI_ARCACHE = C_CACHE;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    S_AXIS_CMD_TREADY = 1'b0;
    M_AXIS_STS_TVALID = 1'b0;
    M_AXIS_STS_TDATA  = '0;
    M_AXIS_TVALID     = 1'b0;
    M_AXIS_TDATA      = '0;
    M_AXIS_TLAST      = 1'b0;
    M_AXI_RREADY      = 1'b0;
    cmd_hs            = 1'b0;
    beat              = 1'b0;
    burst_end         = 1'b0;
    case (state)
      S_IDLE: begin
        S_AXIS_CMD_TREADY = run_r;
        cmd_hs            = S_AXIS_CMD_TVALID && run_r;
        if (cmd_hs) state_nxt = cmd_bad ? S_STS : S_ADDR;
      end
      S_ADDR: begin
        if (arvalid_r && M_AXI_ARREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        // Zero-latency pass-through; beats move only when both sides are ready.
        M_AXIS_TVALID = M_AXI_RVALID;
        M_AXI_RREADY  = M_AXIS_TREADY;
        M_AXIS_TDATA  = M_AXI_RDATA;
        burst_end     = (burst_left == 5'd1);
        M_AXIS_TLAST  = eof_r && burst_end && (beats_rem == 20'd0);
        beat          = M_AXI_RVALID && M_AXIS_TREADY;
        if (beat && burst_end) state_nxt = (beats_rem != 20'd0) ? S_ADDR : S_STS;
      end
      S_STS: begin
        M_AXIS_STS_TVALID = 1'b1;
        M_AXIS_STS_TDATA  = {~(interr_r | decerr_r | slverr_r), slverr_r, decerr_r, interr_r, tag_r};
        if (M_AXIS_STS_TREADY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_r      <= 1'b0;
      addr_r     <= '0;
      araddr_r   <= '0;
      arlen_r    <= '0;
      arvalid_r  <= 1'b0;
      beats_rem  <= '0;
      burst_left <= '0;
      tag_r      <= '0;
      eof_r      <= 1'b0;
      interr_r   <= 1'b0;
      decerr_r   <= 1'b0;
      slverr_r   <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (cmd_hs) begin
        addr_r    <= C_M_AXI_ADDR_WIDTH'(S_AXIS_CMD_TDATA[63:32]);
        beats_rem <= S_AXIS_CMD_TDATA[22:3];
        tag_r     <= S_AXIS_CMD_TDATA[67:64];
        eof_r     <= S_AXIS_CMD_TDATA[30];
        interr_r  <= cmd_bad;
        decerr_r  <= 1'b0;
        slverr_r  <= 1'b0;
      end
      if (issue) begin
        araddr_r   <= addr_r;
        arlen_r    <= {3'd0, burst_w - 5'd1};
        arvalid_r  <= 1'b1;
        addr_r     <= addr_r + C_M_AXI_ADDR_WIDTH'({burst_w, 3'b000});
        beats_rem  <= beats_rem - {15'd0, burst_w};
        burst_left <= burst_w;
      end
      if (arvalid_r && M_AXI_ARREADY) arvalid_r <= 1'b0;
      // Burst end is decided by our own beat count; RLAST only flags protocol errors.
      if (beat) begin
        burst_left <= burst_left - 5'd1;
        if (M_AXI_RRESP == 2'b10) slverr_r <= 1'b1;
        if (M_AXI_RRESP == 2'b11) decerr_r <= 1'b1;
        if (M_AXI_RLAST != burst_end) interr_r <= 1'b1;
      end
    end
  end

`ifdef ACP_MOVER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_cmds  <= '0;
      stat_beats <= '0;
    end else begin
      if (M_AXIS_STS_TVALID && M_AXIS_STS_TREADY) stat_cmds <= stat_cmds + 32'd1;
      if (beat) stat_beats <= stat_beats + 32'd1;
    end
  end
`endif

endmodule
